fir_output_quantizer: RTL and testbench
=======================================

# fir_output_quantizer

Downstream stage of the FIR filter. It accepts full-width signed filter results over a valid/ready handshake and rescales them with an arithmetic right shift, round-half-up and saturation to a narrower output width. Results are buffered in a small first-word-fall-through FIFO and presented to the sink (DAC/serializer interface) on a second valid/ready handshake. The FIR filter's `ov_dout` / `o_dout_valid` / `i_ready` connect directly to this block's `iv_din` / `i_din_valid` / `o_ready`.

## Interface
- `DATA_WIDTH`, 24: input sample width, signed two's complement.
- `OUT_WIDTH`, 16: output sample width, signed; must satisfy `2 <= OUT_WIDTH <= DATA_WIDTH`.
- `SHIFT`, 8: arithmetic right-shift amount; must satisfy `0 <= SHIFT <= DATA_WIDTH-1`.
- `FIFO_DEPTH`, 8: output buffer entries; power of two, at least 4.

Ports:
- `i_clk`, in, 1: single clock; all logic on the rising edge.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_en`, in, 1: global enable; 0 stalls the whole block.
- `iv_din`, in, DATA_WIDTH: signed input sample.
- `i_din_valid`, in, 1: `iv_din` is valid.
- `o_ready`, out, 1: block can accept a sample this cycle.
- `ov_dout`, out, OUT_WIDTH: signed quantized sample at FIFO head.
- `o_dout_valid`, out, 1: FIFO non-empty (and `i_en` = 1).
- `i_ready`, in, 1: sink consumes the head when `o_dout_valid` is also 1.
- `o_sat`, out, 1: sticky flag; at least one sample was saturated since reset.
- `ov_count`, out, $clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- **Accept:** a sample transfers on an edge where `i_din_valid && o_ready`.
- **Flow control:**
  - `o_ready = i_en && (ov_count + v1 + v2 < FIFO_DEPTH)`, where v1 and v2 are the stage-1 and stage-2 valid bits.
  - `o_ready` is combinational from registers only and has no path from `i_ready` or `i_din_valid`.
  - A same-cycle pop is not credited. Under this rule the FIFO can never overflow.
- **Stage 1 (round):** `r1 = sext(iv_din, DATA_WIDTH+1) + (SHIFT>0 ? 2^(SHIFT-1) : 0)`, registered with v1.
- **Stage 2 (shift, saturate):**
  - `q = r1 >>> SHIFT` (arithmetic shift).
  - If `q > 2^(OUT_WIDTH-1)-1`, output the maximum and flag saturation.
  - If `q < -2^(OUT_WIDTH-1)`, output the minimum and flag saturation.
  - Otherwise output the low OUT_WIDTH bits of `q`.
  - The result is registered with v2 and a per-sample saturation bit.
- **FIFO:**
  - Write when v2 = 1.
  - Pop on `o_dout_valid && i_ready`.
  - Simultaneous write and pop leaves `ov_count` unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - `ov_dout` shows the head entry combinationally (first-word fall-through).
- **Saturation flag:** `o_sat` sets on the edge where a saturated sample is written into the FIFO and stays set until `i_rst`.
- **Enable stall (`i_en` = 0):**
  - No accept, no stage advance, no FIFO write or pop.
  - All registers hold.
  - `o_ready` = 0 and `o_dout_valid` = 0.
- **Reset:**
  - Clears v1, v2, both pointers and `o_sat`.
  - Outputs after reset: `o_ready` = 1 when `i_en` = 1; `ov_dout` = 0; `o_dout_valid` = 0; `o_sat` = 0; `ov_count` = 0.
  - Reset mid-stream discards all in-flight and buffered samples. No partial output appears after reset.
- **Empty FIFO:** `ov_dout` holds the last popped value (0 after reset). The sink must not use it while `o_dout_valid` = 0.

## Timing
- **Latency:** a sample accepted at edge N is written to the FIFO at edge N+2. If the FIFO was empty, `o_dout_valid` = 1 in the cycle after edge N+2.
- **Throughput:** one sample per cycle when the sink keeps `i_ready` = 1.
- **Handshake rules:**
  - `o_ready` may deassert at most one cycle after the credit limit is reached.
  - The block never drops an accepted sample.
  - Once raised, `o_dout_valid` stays 1 until the pop, and `ov_dout` is stable until the pop (provided `i_en` = 1).
- **Back-pressure:** `o_ready` reasserts in the cycle after a pop frees credit.
- **FIR pacing:** the FIR filter holds its output until `i_ready`. One transfer per FIR result is therefore guaranteed.

## Test plan
Default parameters (DATA_WIDTH 24, OUT_WIDTH 16, SHIFT 8, FIFO_DEPTH 8) unless stated.

- **Rounding:** inputs 0x000180, 0x000080, 0xFFFF80, 0xFFFF7F with `i_ready` held at 1 -> outputs in order 0x0002, 0x0001, 0x0000, 0xFFFF; `o_sat` stays 0; first `o_dout_valid` 3 cycles after first accept.
- **Saturation:**
  - 0x7FFFFF -> 0x7FFF and `o_sat` = 1.
  - Then 0x800000 -> 0x8000 with no new saturation.
  - `o_sat` stays 1 until `i_rst`.
- **Back-pressure:**
  - With `i_ready` = 0, stream 12 samples with `i_din_valid` held at 1 -> exactly 8 accepted; `ov_count` = 8; `o_ready` = 0.
  - Then raise `i_ready` -> 8 outputs in input order, followed by the remaining 4, with none lost or duplicated.
- **Simultaneous push/pop:** FIFO at 4, accept and pop every cycle for 20 cycles -> `ov_count` constant at 4 and output order preserved.
- **Enable stall:** drop `i_en` for 5 cycles mid-stream -> `o_ready` = 0, `o_dout_valid` = 0, `ov_count` unchanged; resumes with no loss.
- **Reset mid-operation:** assert `i_rst` with 5 buffered and 2 in flight -> next cycle `ov_count` = 0, `o_dout_valid` = 0, `o_sat` = 0; no stale sample ever emerges.

Source files
------------

// File: rtl/fir_output_quantizer.sv
// rtl/fir_output_quantizer.sv - round, shift and saturate FIR results into a first-word-fall-through output FIFO
module fir_output_quantizer #(
  parameter int DATA_WIDTH = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic [DATA_WIDTH-1:0]         iv_din,
  input  logic                          i_din_valid,
  output logic                          o_ready,
  output logic [OUT_WIDTH-1:0]          ov_dout,
  output logic                          o_dout_valid,
  input  logic                          i_ready,
  output logic                          o_sat,
  output logic [$clog2(FIFO_DEPTH):0]   ov_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = DATA_WIDTH + 1;

  localparam logic signed [RW-1:0] RND =
    (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [RW-1:0] QMAX =
    {{(DATA_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [RW-1:0] QMIN =
    {{(DATA_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] OMAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OMIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  logic                  v1_q, v1_d;
  logic signed [RW-1:0]  r1_q, r1_d;
  logic                  v2_q, v2_d;
  logic [OUT_WIDTH-1:0]  q2_q, q2_d;
  logic                  sat2_q, sat2_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  sat_q, sat_d;
  logic [OUT_WIDTH-1:0]  last_q, last_d;
  logic [OUT_WIDTH-1:0]  mem_q [FIFO_DEPTH];

  logic [CW+1:0]         credit;
  logic signed [RW-1:0]  q_shift;
  logic                  accept;
  logic                  push;
  logic                  pop;

  // Credit counts everything already in flight; a pop in this same cycle is deliberately not credited.
  assign credit       = (CW+2)'(count_q) + (CW+2)'(v1_q) + (CW+2)'(v2_q);
  assign o_ready      = i_en && (credit < (CW+2)'(FIFO_DEPTH));
  assign o_dout_valid = i_en && (count_q != '0);
  assign accept       = i_din_valid && o_ready;
  assign push         = i_en && v2_q;
  assign pop          = o_dout_valid && i_ready;
  assign q_shift      = r1_q >>> SHIFT;

  assign ov_dout  = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign ov_count = count_q;
  assign o_sat    = sat_q;

  always_comb begin
    v1_d   = v1_q;
    r1_d   = r1_q;
    v2_d   = v2_q;
    q2_d   = q2_q;
    sat2_d = sat2_q;
    if (i_en) begin
      v1_d = accept;
      if (accept) begin
        r1_d = {iv_din[DATA_WIDTH-1], iv_din} + RND;
      end
      v2_d = v1_q;
      if (v1_q) begin
        if (q_shift > QMAX) begin
          q2_d   = OMAX;
          sat2_d = 1'b1;
        end else if (q_shift < QMIN) begin
          q2_d   = OMIN;
          sat2_d = 1'b1;
        end else begin
          q2_d   = q_shift[OUT_WIDTH-1:0];
          sat2_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    sat_d    = sat_q | (push & sat2_q);
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q     <= 1'b0;
      r1_q     <= '0;
      v2_q     <= 1'b0;
      q2_q     <= '0;
      sat2_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sat_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      v1_q     <= v1_d;
      r1_q     <= r1_d;
      v2_q     <= v2_d;
      q2_q     <= q2_d;
      sat2_q   <= sat2_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: pointers and count gate every read that matters.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= q2_q;
    end
  end

endmodule

// File: tb/tb_fir_output_quantizer.sv
// tb/tb_fir_output_quantizer.sv - directed self-checking bench for fir_output_quantizer
module tb_fir_output_quantizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [23:0] din;
  logic        din_valid;
  logic        o_ready;
  logic [15:0] dout;
  logic        dout_valid;
  logic        rdy;
  logic        sat;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] got[$];

  fir_output_quantizer #(
    .DATA_WIDTH(24), .OUT_WIDTH(16), .SHIFT(8), .FIFO_DEPTH(8)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .iv_din(din), .i_din_valid(din_valid), .o_ready(o_ready),
    .ov_dout(dout), .o_dout_valid(dout_valid), .i_ready(rdy),
    .o_sat(sat), .ov_count(count)
  );

  always #5 clk = ~clk;

  initial begin
    rst = 1'b1; en = 1'b1; din = '0; din_valid = 1'b0; rdy = 1'b0;
  end

  task automatic step(input logic r, input logic e, input logic v, input logic [23:0] d,
                      input logic rd, output logic acc, output logic pp, output logic [15:0] dq);
    @(negedge clk);
    rst = r; en = e; din_valid = v; din = d; rdy = rd;
    #1;
    acc = v && o_ready;
    pp  = dout_valid && rd;
    dq  = dout;
  endtask

  function automatic logic [23:0] smp(input int k);
    return 24'(k * 256);
  endfunction

  task automatic test_reset();
    logic a, p; logic [15:0] d;
    step(1, 1, 0, '0, 0, a, p, d);
    step(1, 1, 0, '0, 0, a, p, d);
    step(0, 1, 0, '0, 0, a, p, d);
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b expected 1", o_ready); end
    n_cmp++; if (dout !== 16'h0) begin n_err++; $display("FAIL rst_dout: got %h expected 0000", dout); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", dout_valid); end
    n_cmp++; if (sat !== 1'b0) begin n_err++; $display("FAIL rst_sat: got %b expected 0", sat); end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count); end
  endtask

  task automatic test_rounding();
    logic a, p; logic [15:0] d;
    logic [23:0] vin [4];
    logic [15:0] exp_q [4];
    int idx = 0; int first_acc = -1; int first_val = -1; logic sat_seen = 1'b0;
    vin   = '{24'h000180, 24'h000080, 24'hFFFF80, 24'hFFFF7F};
    exp_q = '{16'h0002, 16'h0001, 16'h0000, 16'hFFFF};
    got.delete();
    for (int t = 0; t < 20; t++) begin
      step(0, 1, idx < 4, (idx < 4) ? vin[idx] : 24'h0, 1, a, p, d);
      if (a && first_acc < 0) first_acc = t;
      if (a) idx++;
      if (p) begin if (first_val < 0) first_val = t; got.push_back(d); end
      if (sat !== 1'b0) sat_seen = 1'b1;
    end
    n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL round_num: got %0d expected 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== exp_q[i]) begin
        n_err++; $display("FAIL round_out%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 16'hxxxx, exp_q[i]);
      end
    end
    n_cmp++; if (first_val - first_acc != 3) begin n_err++; $display("FAIL round_latency: got %0d expected 3", first_val - first_acc); end
    n_cmp++; if (sat_seen !== 1'b0) begin n_err++; $display("FAIL round_sat: got 1 expected 0"); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL round_empty_valid: got %b expected 0", dout_valid); end
    n_cmp++; if (dout !== 16'hFFFF) begin n_err++; $display("FAIL round_hold_last: got %h expected ffff", dout); end
  endtask

  task automatic test_saturation();
    logic a, p; logic [15:0] d;
    logic [23:0] vin [2];
    logic sat_at [20];
    int idx = 0; int first_acc = -1;
    vin = '{24'h7FFFFF, 24'h800000};
    got.delete();
    for (int t = 0; t < 20; t++) begin
      step(0, 1, idx < 2, (idx < 2) ? vin[idx] : 24'h0, 1, a, p, d);
      if (a && first_acc < 0) first_acc = t;
      if (a) idx++;
      if (p) got.push_back(d);
      sat_at[t] = sat;
    end
    n_cmp++; if (got.size() != 2) begin n_err++; $display("FAIL sat_num: got %0d expected 2", got.size()); end
    n_cmp++; if (got.size() < 1 || got[0] !== 16'h7FFF) begin n_err++; $display("FAIL sat_pos: got %h expected 7fff", (got.size() > 0) ? got[0] : 16'hxxxx); end
    n_cmp++; if (got.size() < 2 || got[1] !== 16'h8000) begin n_err++; $display("FAIL sat_neg: got %h expected 8000", (got.size() > 1) ? got[1] : 16'hxxxx); end
    n_cmp++; if (first_acc < 0 || first_acc > 16 || sat_at[first_acc + 2] !== 1'b0) begin n_err++; $display("FAIL sat_early: got 1 expected 0 before FIFO write"); end
    n_cmp++; if (first_acc < 0 || first_acc > 16 || sat_at[first_acc + 3] !== 1'b1) begin n_err++; $display("FAIL sat_set: got 0 expected 1 after FIFO write"); end
    n_cmp++; if (sat !== 1'b1) begin n_err++; $display("FAIL sat_sticky: got %b expected 1", sat); end
  endtask

  task automatic test_backpressure();
    logic a, p; logic [15:0] d;
    int idx = 0; int early_pops = 0;
    got.delete();
    for (int t = 0; t < 16; t++) begin
      step(0, 1, idx < 12, smp(idx + 1), 0, a, p, d);
      if (a) idx++;
      if (p) early_pops++;
    end
    n_cmp++; if (idx != 8) begin n_err++; $display("FAIL bp_accepted: got %0d expected 8", idx); end
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL bp_count: got %0d expected 8", count); end
    n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b expected 0", o_ready); end
    n_cmp++; if (early_pops != 0) begin n_err++; $display("FAIL bp_early_pop: got %0d expected 0", early_pops); end
    for (int t = 0; t < 60; t++) begin
      step(0, 1, idx < 12, smp(idx + 1), 1, a, p, d);
      if (a) idx++;
      if (p) got.push_back(d);
    end
    n_cmp++; if (got.size() != 12) begin n_err++; $display("FAIL bp_num: got %0d expected 12", got.size()); end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== 16'(i + 1)) begin
        n_err++; $display("FAIL bp_out%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 16'hxxxx, 16'(i + 1));
      end
    end
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL bp_drain: got %0d expected 0", count); end
  endtask

  task automatic test_push_pop();
    logic a, p; logic [15:0] d;
    int idx = 0;
    got.delete();
    for (int t = 0; t < 6; t++) begin
      step(0, 1, 1, smp(idx + 1), 0, a, p, d);
      if (a) idx++;
    end
    for (int t = 0; t < 20; t++) begin
      step(0, 1, 1, smp(idx + 1), 1, a, p, d);
      if (a) idx++;
      if (p) got.push_back(d);
      n_cmp++; if (count !== 4'd4) begin n_err++; $display("FAIL pp_count_c%0d: got %0d expected 4", t, count); end
    end
    for (int t = 0; t < 10; t++) begin
      step(0, 1, 0, '0, 1, a, p, d);
      if (p) got.push_back(d);
    end
    n_cmp++; if (idx != 26) begin n_err++; $display("FAIL pp_accepted: got %0d expected 26", idx); end
    n_cmp++; if (got.size() != 26) begin n_err++; $display("FAIL pp_num: got %0d expected 26", got.size()); end
    for (int i = 0; i < 26; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== 16'(i + 1)) begin
        n_err++; $display("FAIL pp_out%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 16'hxxxx, 16'(i + 1));
      end
    end
  endtask

  task automatic test_enable_stall();
    logic a, p; logic [15:0] d; logic e;
    int idx = 0;
    got.delete();
    for (int t = 0; t < 30; t++) begin
      e = !(t >= 3 && t < 8);
      step(0, e, idx < 10, smp(idx + 101), 1, a, p, d);
      if (a) idx++;
      if (p) got.push_back(d);
      if (!e) begin
        n_cmp++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_c%0d: got %b expected 0", t, o_ready); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid_c%0d: got %b expected 0", t, dout_valid); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL stall_count_c%0d: got %0d expected 1", t, count); end
      end
    end
    n_cmp++; if (got.size() != 10) begin n_err++; $display("FAIL stall_num: got %0d expected 10", got.size()); end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (i >= got.size() || got[i] !== 16'(i + 101)) begin
        n_err++; $display("FAIL stall_out%0d: got %h expected %h", i, (i < got.size()) ? got[i] : 16'hxxxx, 16'(i + 101));
      end
    end
    n_cmp++; if (sat !== 1'b1) begin n_err++; $display("FAIL stall_sat_sticky: got %b expected 1", sat); end
  endtask

  task automatic test_reset_mid();
    logic a, p; logic [15:0] d;
    int idx = 0; int stale = 0;
    got.delete();
    for (int t = 0; t < 7; t++) begin
      step(0, 1, 1, smp(idx + 1), 0, a, p, d);
      if (a) idx++;
    end
    step(1, 1, 0, '0, 0, a, p, d);
    n_cmp++; if (idx != 7) begin n_err++; $display("FAIL rm_accepted: got %0d expected 7", idx); end
    n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL rm_prefill: got %0d expected 5", count); end
    step(0, 1, 0, '0, 1, a, p, d);
    if (p) stale++;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL rm_count: got %0d expected 0", count); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b expected 0", dout_valid); end
    n_cmp++; if (sat !== 1'b0) begin n_err++; $display("FAIL rm_sat: got %b expected 0", sat); end
    n_cmp++; if (o_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready: got %b expected 1", o_ready); end
    n_cmp++; if (dout !== 16'h0) begin n_err++; $display("FAIL rm_dout: got %h expected 0000", dout); end
    for (int t = 0; t < 10; t++) begin
      step(0, 1, 0, '0, 1, a, p, d);
      if (p) stale++;
    end
    n_cmp++; if (stale != 0) begin n_err++; $display("FAIL rm_stale: got %0d expected 0", stale); end
    idx = 0;
    for (int t = 0; t < 10; t++) begin
      step(0, 1, idx < 1, 24'h000500, 1, a, p, d);
      if (a) idx++;
      if (p) got.push_back(d);
    end
    n_cmp++; if (got.size() != 1) begin n_err++; $display("FAIL rm_num: got %0d expected 1", got.size()); end
    n_cmp++; if (got.size() < 1 || got[0] !== 16'h0005) begin n_err++; $display("FAIL rm_fresh: got %h expected 0005", (got.size() > 0) ? got[0] : 16'hxxxx); end
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_push_pop();
    test_enable_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
